// File: rtl/pcie_app_pkg.sv
// Shared types for the PCIe application-side request path.
package pcie_app_pkg;

    typedef enum logic [1:0] {
        TT_NONE  = 2'd0,
        TT_MRD   = 2'd1,
        TT_MWR   = 2'd2,
        TT_UNSUP = 2'd3
    } trans_type_e;

    typedef enum logic [2:0] {
        CPL_SC = 3'b000,
        CPL_UR = 3'b001,
        CPL_CA = 3'b100
    } cpl_status_e;

    typedef struct packed {
        logic [2:0] fmt;
        logic [4:0] pktType;
        logic [7:0] tcRsvd;
        logic       td;
        logic       ep;
        logic [1:0] attr;
        logic [1:0] at;
        logic [9:0] length;
    } hdr0_type;

    typedef struct packed {
        logic [15:0] requesterId;
        logic [7:0]  tag;
        logic [3:0]  lastBe;
        logic [3:0]  firstBe;
    } hdr1_type;

    // A request is only serviceable when it uses a 3DW header and a QW-aligned address.
    function automatic logic isAligned(input logic is3dw, input logic qwAligned);
        return is3dw & qwAligned;
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16 (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iINC,
    output logic [15:0] oCOUNT
);

    logic [15:0] count_q;

    // Count enabled events, clearing synchronously and holding at the maximum.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            count_q <= 16'h0000;
        end else if (iINC && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign oCOUNT = count_q;

endmodule

// File: rtl/rx_req_dispatch.sv
// Dispatches one decoded MRd/MWr at a time to a register-bank target and
// produces the completion request for non-posted reads.
module rx_req_dispatch
    import pcie_app_pkg::*;
#(
    parameter int NUM_TGT     = 4,
    parameter int TGT_SEL_LSB = 20,
    parameter int TGT_SEL_W   = 2,
    parameter int RD_TIMEOUT  = 255
) (
    input  logic                         iCLK,
    input  logic                         iRST_N,
    input  logic                         iDECODE_VALID,
    input  trans_type_e                  iTRANS_TYPE,
    input  hdr0_type                     iHDR0,
    input  hdr1_type                     iHDR1,
    input  logic [29:0]                  iADDR,
    input  logic [63:0]                  iWR_DATA,
    input  logic                         iTLP_UR,
    input  logic                         iTLP_EP,
    input  logic                         iTLP_3DW_4DW_n,
    input  logic                         iTLP_ADDR_QWALIGNED,
    output logic                         oDONE_PULSE,
    output logic [NUM_TGT-1:0]           oTGT_WR,
    output logic [NUM_TGT-1:0]           oTGT_RD,
    output logic [29:0]                  oTGT_ADDR,
    output logic [63:0]                  oTGT_WR_DATA,
    input  logic [NUM_TGT-1:0]           iTGT_RD_VALID,
    input  logic [NUM_TGT-1:0][63:0]     iTGT_RD_DATA,
    output logic                         oCPL_REQ,
    output cpl_status_e                  oCPL_STATUS,
    output logic [63:0]                  oCPL_DATA,
    output hdr0_type                     oCPL_HDR0,
    output hdr1_type                     oCPL_HDR1,
    input  logic                         iCPL_ACK,
    output logic [15:0]                  oDROP_CNT,
    output logic [15:0]                  oRD_TIMEOUT_CNT
);

    typedef enum logic [2:0] {
        IDLE_ST,
        WR_ST,
        RD_REQ_ST,
        RD_WAIT_ST,
        CPL_ST,
        DONE_ST,
        WAIT_DROP_ST
    } state_e;

    localparam logic [7:0] RdTimeoutL = 8'(RD_TIMEOUT);

    state_e                 state_q;
    logic [TGT_SEL_W-1:0]   tgt_q;
    logic [29:0]            addr_q;
    logic [63:0]            wrData_q;
    hdr0_type               hdr0_q;
    hdr1_type               hdr1_q;
    logic [NUM_TGT-1:0]     wrStrobe_q;
    logic [NUM_TGT-1:0]     rdStrobe_q;
    logic                   done_q;
    logic                   cplReq_q;
    cpl_status_e            cplStatus_q;
    logic [63:0]            cplData_q;
    logic [7:0]             timer_q;
    logic                   dropInc_q;
    logic                   timeoutInc_q;

    logic [TGT_SEL_W-1:0]   tgtIn;
    logic                   okSel;
    logic                   okAlign;
    logic [NUM_TGT-1:0]     inOneHot;
    logic                   selValid;
    logic [63:0]            selData;

    assign tgtIn    = iADDR[TGT_SEL_LSB +: TGT_SEL_W];
    assign okSel    = (32'(tgtIn) < NUM_TGT);
    assign okAlign  = isAligned(iTLP_3DW_4DW_n, iTLP_ADDR_QWALIGNED);
    assign inOneHot = NUM_TGT'(1) << tgtIn;
    assign selValid = iTGT_RD_VALID[tgt_q];
    assign selData  = iTGT_RD_DATA[tgt_q];

    // Request sequencer: classifies the incoming TLP, strobes the target,
    // waits for read data or timeout, holds the completion, then hands back to the decoder.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q      <= IDLE_ST;
            tgt_q        <= '0;
            addr_q       <= '0;
            wrData_q     <= '0;
            hdr0_q       <= '0;
            hdr1_q       <= '0;
            wrStrobe_q   <= '0;
            rdStrobe_q   <= '0;
            done_q       <= 1'b0;
            cplReq_q     <= 1'b0;
            cplStatus_q  <= CPL_SC;
            cplData_q    <= '0;
            timer_q      <= '0;
            dropInc_q    <= 1'b0;
            timeoutInc_q <= 1'b0;
        end else begin
            wrStrobe_q   <= '0;
            rdStrobe_q   <= '0;
            done_q       <= 1'b0;
            dropInc_q    <= 1'b0;
            timeoutInc_q <= 1'b0;
            case (state_q)
                IDLE_ST: begin
                    if (iDECODE_VALID) begin
                        tgt_q    <= tgtIn;
                        addr_q   <= iADDR;
                        wrData_q <= iWR_DATA;
                        hdr0_q   <= iHDR0;
                        hdr1_q   <= iHDR1;
                        if (iTLP_EP) begin
                            dropInc_q <= 1'b1;
                            state_q   <= WAIT_DROP_ST;
                        end else if (iTLP_UR) begin
                            cplStatus_q <= CPL_UR;
                            cplData_q   <= '0;
                            cplReq_q    <= 1'b1;
                            state_q     <= CPL_ST;
                        end else begin
                            case (iTRANS_TYPE)
                                TT_MWR: begin
                                    if (okSel && okAlign) begin
                                        wrStrobe_q <= inOneHot;
                                        state_q    <= WR_ST;
                                    end else begin
                                        dropInc_q <= 1'b1;
                                        done_q    <= 1'b1;
                                        state_q   <= DONE_ST;
                                    end
                                end
                                TT_MRD: begin
                                    if (okSel && okAlign) begin
                                        rdStrobe_q <= inOneHot;
                                        state_q    <= RD_REQ_ST;
                                    end else begin
                                        cplStatus_q <= CPL_UR;
                                        cplData_q   <= '0;
                                        cplReq_q    <= 1'b1;
                                        state_q     <= CPL_ST;
                                    end
                                end
                                default: begin
                                    dropInc_q <= 1'b1;
                                    state_q   <= WAIT_DROP_ST;
                                end
                            endcase
                        end
                    end
                end
                WR_ST: begin
                    done_q  <= 1'b1;
                    state_q <= DONE_ST;
                end
                RD_REQ_ST: begin
                    timer_q <= RdTimeoutL;
                    state_q <= RD_WAIT_ST;
                end
                RD_WAIT_ST: begin
                    if (selValid) begin
                        cplStatus_q <= CPL_SC;
                        cplData_q   <= selData;
                        cplReq_q    <= 1'b1;
                        state_q     <= CPL_ST;
                    end else if (timer_q <= 8'd1) begin
                        cplStatus_q  <= CPL_CA;
                        cplData_q    <= '0;
                        cplReq_q     <= 1'b1;
                        timeoutInc_q <= 1'b1;
                        timer_q      <= '0;
                        state_q      <= CPL_ST;
                    end else begin
                        timer_q <= timer_q - 8'd1;
                    end
                end
                CPL_ST: begin
                    if (iCPL_ACK) begin
                        cplReq_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE_ST;
                    end
                end
                DONE_ST: begin
                    state_q <= WAIT_DROP_ST;
                end
                WAIT_DROP_ST: begin
                    if (!iDECODE_VALID) begin
                        state_q <= IDLE_ST;
                    end
                end
                default: begin
                    state_q <= IDLE_ST;
                end
            endcase
        end
    end

    sat_counter16 uDropCnt (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .iINC   (dropInc_q),
        .oCOUNT (oDROP_CNT)
    );

    sat_counter16 uTimeoutCnt (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .iINC   (timeoutInc_q),
        .oCOUNT (oRD_TIMEOUT_CNT)
    );

    assign oDONE_PULSE  = done_q;
    assign oTGT_WR      = wrStrobe_q;
    assign oTGT_RD      = rdStrobe_q;
    assign oTGT_ADDR    = addr_q;
    assign oTGT_WR_DATA = wrData_q;
    assign oCPL_REQ     = cplReq_q;
    assign oCPL_STATUS  = cplStatus_q;
    assign oCPL_DATA    = cplData_q;
    assign oCPL_HDR0    = hdr0_q;
    assign oCPL_HDR1    = hdr1_q;

endmodule

// File: tb/tb_rx_req_dispatch.sv
// Directed bench for rx_req_dispatch: a classification table plus hand-written
// read, timeout, stale-valid and mid-completion reset sequences.
module tb_rx_req_dispatch;
    import pcie_app_pkg::*;

    localparam int NT = 5;

    logic                 iCLK;
    logic                 iRST_N;
    logic                 iDECODE_VALID;
    trans_type_e          iTRANS_TYPE;
    hdr0_type             iHDR0;
    hdr1_type             iHDR1;
    logic [29:0]          iADDR;
    logic [63:0]          iWR_DATA;
    logic                 iTLP_UR;
    logic                 iTLP_EP;
    logic                 iTLP_3DW_4DW_n;
    logic                 iTLP_ADDR_QWALIGNED;
    logic                 oDONE_PULSE;
    logic [NT-1:0]        oTGT_WR;
    logic [NT-1:0]        oTGT_RD;
    logic [29:0]          oTGT_ADDR;
    logic [63:0]          oTGT_WR_DATA;
    logic [NT-1:0]        iTGT_RD_VALID;
    logic [NT-1:0][63:0]  iTGT_RD_DATA;
    logic                 oCPL_REQ;
    cpl_status_e          oCPL_STATUS;
    logic [63:0]          oCPL_DATA;
    hdr0_type             oCPL_HDR0;
    hdr1_type             oCPL_HDR1;
    logic                 iCPL_ACK;
    logic [15:0]          oDROP_CNT;
    logic [15:0]          oRD_TIMEOUT_CNT;

    int checkCount = 0;
    int passCount  = 0;
    int expDrop    = 0;

    rx_req_dispatch #(
        .NUM_TGT     (NT),
        .TGT_SEL_LSB (20),
        .TGT_SEL_W   (3),
        .RD_TIMEOUT  (255)
    ) dut (
        .iCLK                (iCLK),
        .iRST_N              (iRST_N),
        .iDECODE_VALID       (iDECODE_VALID),
        .iTRANS_TYPE         (iTRANS_TYPE),
        .iHDR0               (iHDR0),
        .iHDR1               (iHDR1),
        .iADDR               (iADDR),
        .iWR_DATA            (iWR_DATA),
        .iTLP_UR             (iTLP_UR),
        .iTLP_EP             (iTLP_EP),
        .iTLP_3DW_4DW_n      (iTLP_3DW_4DW_n),
        .iTLP_ADDR_QWALIGNED (iTLP_ADDR_QWALIGNED),
        .oDONE_PULSE         (oDONE_PULSE),
        .oTGT_WR             (oTGT_WR),
        .oTGT_RD             (oTGT_RD),
        .oTGT_ADDR           (oTGT_ADDR),
        .oTGT_WR_DATA        (oTGT_WR_DATA),
        .iTGT_RD_VALID       (iTGT_RD_VALID),
        .iTGT_RD_DATA        (iTGT_RD_DATA),
        .oCPL_REQ            (oCPL_REQ),
        .oCPL_STATUS         (oCPL_STATUS),
        .oCPL_DATA           (oCPL_DATA),
        .oCPL_HDR0           (oCPL_HDR0),
        .oCPL_HDR1           (oCPL_HDR1),
        .iCPL_ACK            (iCPL_ACK),
        .oDROP_CNT           (oDROP_CNT),
        .oRD_TIMEOUT_CNT     (oRD_TIMEOUT_CNT)
    );

    // Free-running 100 MHz clock.
    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    typedef struct {
        trans_type_e tt;
        logic [29:0] addr;
        logic [63:0] data;
        logic        ur;
        logic        ep;
        logic        is3dw;
        logic        aligned;
        logic [7:0]  tag;
        logic [NT-1:0] expWr;
        logic        expDone1;
        logic        expCpl;
        cpl_status_e expStatus;
        int          dropInc;
    } vec_t;

    vec_t vecs [11];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input trans_type_e tt, input logic [29:0] addr, input logic [63:0] data,
                                 input logic ur, input logic ep, input logic is3dw, input logic aligned,
                                 input logic [7:0] tag);
        hdr0_type h0;
        hdr1_type h1;
        h0 = '0;
        h0.length = 10'd2;
        h1 = '0;
        h1.requesterId = 16'hABCD;
        h1.tag = tag;
        h1.firstBe = 4'hF;
        h1.lastBe = 4'hF;
        iTRANS_TYPE = tt;
        iADDR = addr;
        iWR_DATA = data;
        iTLP_UR = ur;
        iTLP_EP = ep;
        iTLP_3DW_4DW_n = is3dw;
        iTLP_ADDR_QWALIGNED = aligned;
        iHDR0 = h0;
        iHDR1 = h1;
        iDECODE_VALID = 1'b1;
    endtask

    // Decoder keeps valid up for two more cycles, then drops it and the DUT returns to idle.
    task automatic endTxn();
        repeat (2) @(negedge iCLK);
        iDECODE_VALID = 1'b0;
        repeat (2) @(negedge iCLK);
    endtask

    initial begin
        int n;
        int wrCount;
        int doneCount;

        iRST_N = 1'b0;
        iDECODE_VALID = 1'b0;
        iTRANS_TYPE = TT_NONE;
        iHDR0 = '0;
        iHDR1 = '0;
        iADDR = '0;
        iWR_DATA = '0;
        iTLP_UR = 1'b0;
        iTLP_EP = 1'b0;
        iTLP_3DW_4DW_n = 1'b1;
        iTLP_ADDR_QWALIGNED = 1'b1;
        iTGT_RD_VALID = '0;
        iTGT_RD_DATA = '0;
        iCPL_ACK = 1'b0;

        vecs[0]  = '{TT_MWR,   30'h0010_0004, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 5'b00010, 1'b0, 1'b0, CPL_SC, 0};
        vecs[1]  = '{TT_MWR,   30'h0040_0010, 64'h0000_1111_2222_3333, 1'b0, 1'b0, 1'b1, 1'b1, 8'h02, 5'b10000, 1'b0, 1'b0, CPL_SC, 0};
        vecs[2]  = '{TT_MWR,   30'h0050_0000, 64'h5555_5555_5555_5555, 1'b0, 1'b0, 1'b1, 1'b1, 8'h03, 5'b00000, 1'b1, 1'b0, CPL_SC, 1};
        vecs[3]  = '{TT_MWR,   30'h0000_0008, 64'h6666_6666_6666_6666, 1'b0, 1'b0, 1'b1, 1'b0, 8'h04, 5'b00000, 1'b1, 1'b0, CPL_SC, 1};
        vecs[4]  = '{TT_MRD,   30'h0020_0000, 64'h0,                   1'b1, 1'b0, 1'b1, 1'b1, 8'h15, 5'b00000, 1'b0, 1'b1, CPL_UR, 0};
        vecs[5]  = '{TT_MRD,   30'h0020_0000, 64'h0,                   1'b0, 1'b0, 1'b1, 1'b0, 8'h16, 5'b00000, 1'b0, 1'b1, CPL_UR, 0};
        vecs[6]  = '{TT_MRD,   30'h0020_0000, 64'h0,                   1'b0, 1'b0, 1'b0, 1'b1, 8'h17, 5'b00000, 1'b0, 1'b1, CPL_UR, 0};
        vecs[7]  = '{TT_MRD,   30'h0060_0000, 64'h0,                   1'b0, 1'b0, 1'b1, 1'b1, 8'h18, 5'b00000, 1'b0, 1'b1, CPL_UR, 0};
        vecs[8]  = '{TT_UNSUP, 30'h0010_0000, 64'h0,                   1'b0, 1'b0, 1'b1, 1'b1, 8'h19, 5'b00000, 1'b0, 1'b0, CPL_SC, 1};
        vecs[9]  = '{TT_MWR,   30'h0010_0000, 64'h7777_7777_7777_7777, 1'b0, 1'b1, 1'b1, 1'b1, 8'h1A, 5'b00000, 1'b0, 1'b0, CPL_SC, 1};
        vecs[10] = '{TT_MWR,   30'h0000_0020, 64'h8888_9999_AAAA_BBBB, 1'b0, 1'b0, 1'b1, 1'b1, 8'h1B, 5'b00001, 1'b0, 1'b0, CPL_SC, 0};

        // Reset state
        repeat (3) @(negedge iCLK);
        checkOutput("rst_done", 64'(oDONE_PULSE), 64'd0);
        checkOutput("rst_wr", 64'(oTGT_WR), 64'd0);
        checkOutput("rst_rd", 64'(oTGT_RD), 64'd0);
        checkOutput("rst_cplreq", 64'(oCPL_REQ), 64'd0);
        checkOutput("rst_status", 64'(oCPL_STATUS), 64'(CPL_SC));
        checkOutput("rst_drop", 64'(oDROP_CNT), 64'd0);
        checkOutput("rst_tocnt", 64'(oRD_TIMEOUT_CNT), 64'd0);
        iRST_N = 1'b1;
        repeat (2) @(negedge iCLK);

        // Classification table
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].tt, vecs[i].addr, vecs[i].data, vecs[i].ur, vecs[i].ep,
                          vecs[i].is3dw, vecs[i].aligned, vecs[i].tag);
            @(negedge iCLK);
            checkOutput($sformatf("v%0d_wr", i), 64'(oTGT_WR), 64'(vecs[i].expWr));
            checkOutput($sformatf("v%0d_rd", i), 64'(oTGT_RD), 64'd0);
            checkOutput($sformatf("v%0d_done1", i), 64'(oDONE_PULSE), 64'(vecs[i].expDone1));
            checkOutput($sformatf("v%0d_cplreq", i), 64'(oCPL_REQ), 64'(vecs[i].expCpl));
            if (vecs[i].expWr != '0) begin
                checkOutput($sformatf("v%0d_addr", i), 64'(oTGT_ADDR), 64'(vecs[i].addr));
                checkOutput($sformatf("v%0d_wdata", i), oTGT_WR_DATA, vecs[i].data);
                @(negedge iCLK);
                checkOutput($sformatf("v%0d_wr_off", i), 64'(oTGT_WR), 64'd0);
                checkOutput($sformatf("v%0d_done2", i), 64'(oDONE_PULSE), 64'd1);
                checkOutput($sformatf("v%0d_nocpl", i), 64'(oCPL_REQ), 64'd0);
            end
            if (vecs[i].expCpl) begin
                checkOutput($sformatf("v%0d_status", i), 64'(oCPL_STATUS), 64'(vecs[i].expStatus));
                checkOutput($sformatf("v%0d_cdata", i), oCPL_DATA, 64'd0);
                checkOutput($sformatf("v%0d_tag", i), 64'(oCPL_HDR1.tag), 64'(vecs[i].tag));
                iCPL_ACK = 1'b1;
                @(negedge iCLK);
                iCPL_ACK = 1'b0;
                checkOutput($sformatf("v%0d_cpl_done", i), 64'(oDONE_PULSE), 64'd1);
                checkOutput($sformatf("v%0d_cpl_off", i), 64'(oCPL_REQ), 64'd0);
            end
            expDrop += vecs[i].dropInc;
            endTxn();
            checkOutput($sformatf("v%0d_dropcnt", i), 64'(oDROP_CNT), 64'(expDrop));
        end

        // MRd to target 2, answered five cycles after the strobe
        applyStimulus(TT_MRD, 30'h0020_0008, 64'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A);
        @(negedge iCLK);
        checkOutput("rd2_strobe", 64'(oTGT_RD), 64'(5'b00100));
        iTGT_RD_VALID = 5'b00001;
        iTGT_RD_DATA[0] = 64'hBAD0_BAD0_BAD0_BAD0;
        repeat (4) @(negedge iCLK);
        checkOutput("rd2_nosel_ignored", 64'(oCPL_REQ), 64'd0);
        checkOutput("rd2_strobe_1cyc", 64'(oTGT_RD), 64'd0);
        iTGT_RD_VALID = 5'b00100;
        iTGT_RD_DATA[2] = 64'h1122_3344_5566_7788;
        @(negedge iCLK);
        iTGT_RD_VALID = '0;
        iTGT_RD_DATA = '0;
        checkOutput("rd2_cplreq", 64'(oCPL_REQ), 64'd1);
        checkOutput("rd2_status", 64'(oCPL_STATUS), 64'(CPL_SC));
        checkOutput("rd2_data", oCPL_DATA, 64'h1122_3344_5566_7788);
        checkOutput("rd2_tag", 64'(oCPL_HDR1.tag), 64'h5A);
        checkOutput("rd2_reqid", 64'(oCPL_HDR1.requesterId), 64'hABCD);
        repeat (2) @(negedge iCLK);
        checkOutput("rd2_hold_req", 64'(oCPL_REQ), 64'd1);
        checkOutput("rd2_hold_data", oCPL_DATA, 64'h1122_3344_5566_7788);
        checkOutput("rd2_no_early_done", 64'(oDONE_PULSE), 64'd0);
        iCPL_ACK = 1'b1;
        @(negedge iCLK);
        iCPL_ACK = 1'b0;
        checkOutput("rd2_done", 64'(oDONE_PULSE), 64'd1);
        checkOutput("rd2_req_off", 64'(oCPL_REQ), 64'd0);
        @(negedge iCLK);
        checkOutput("rd2_done_1cyc", 64'(oDONE_PULSE), 64'd0);
        endTxn();

        // MRd to target 3 with no response: completer abort after the timeout
        applyStimulus(TT_MRD, 30'h0030_0000, 64'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h33);
        @(negedge iCLK);
        checkOutput("to_strobe", 64'(oTGT_RD), 64'(5'b01000));
        n = 0;
        while (!oCPL_REQ && n < 400) begin
            @(negedge iCLK);
            n++;
        end
        checkOutput("to_latency_in_window", 64'((n >= 255) && (n <= 256)), 64'd1);
        checkOutput("to_status", 64'(oCPL_STATUS), 64'(CPL_CA));
        checkOutput("to_data", oCPL_DATA, 64'd0);
        iTGT_RD_VALID = 5'b01000;
        iTGT_RD_DATA[3] = 64'hFFFF_0000_FFFF_0000;
        @(negedge iCLK);
        iTGT_RD_VALID = '0;
        iTGT_RD_DATA = '0;
        checkOutput("to_late_data_ignored", oCPL_DATA, 64'd0);
        checkOutput("to_late_status", 64'(oCPL_STATUS), 64'(CPL_CA));
        checkOutput("to_tocnt", 64'(oRD_TIMEOUT_CNT), 64'd1);
        iCPL_ACK = 1'b1;
        @(negedge iCLK);
        iCPL_ACK = 1'b0;
        checkOutput("to_done", 64'(oDONE_PULSE), 64'd1);
        endTxn();

        // Valid held high well past done: exactly one dispatch
        applyStimulus(TT_MWR, 30'h0020_0000, 64'h0102_0304_0506_0708, 1'b0, 1'b0, 1'b1, 1'b1, 8'h44);
        wrCount = 0;
        doneCount = 0;
        repeat (12) begin
            @(negedge iCLK);
            if (oTGT_WR != '0) wrCount++;
            if (oDONE_PULSE) doneCount++;
        end
        iDECODE_VALID = 1'b0;
        repeat (2) @(negedge iCLK);
        checkOutput("hold_wr_count", 64'(wrCount), 64'd1);
        checkOutput("hold_done_count", 64'(doneCount), 64'd1);

        // Reset while a completion is pending
        applyStimulus(TT_MRD, 30'h0010_0000, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h66);
        @(negedge iCLK);
        checkOutput("mrst_in_cpl", 64'(oCPL_REQ), 64'd1);
        iRST_N = 1'b0;
        @(negedge iCLK);
        iDECODE_VALID = 1'b0;
        checkOutput("mrst_cplreq", 64'(oCPL_REQ), 64'd0);
        checkOutput("mrst_status", 64'(oCPL_STATUS), 64'(CPL_SC));
        checkOutput("mrst_done", 64'(oDONE_PULSE), 64'd0);
        checkOutput("mrst_addr", 64'(oTGT_ADDR), 64'd0);
        checkOutput("mrst_drop", 64'(oDROP_CNT), 64'd0);
        checkOutput("mrst_tocnt", 64'(oRD_TIMEOUT_CNT), 64'd0);
        iRST_N = 1'b1;
        repeat (2) @(negedge iCLK);
        checkOutput("mrst_no_done_after", 64'(oDONE_PULSE), 64'd0);
        applyStimulus(TT_MRD, 30'h0010_0010, 64'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h77);
        @(negedge iCLK);
        checkOutput("post_rd_strobe", 64'(oTGT_RD), 64'(5'b00010));
        @(negedge iCLK);
        iTGT_RD_VALID = 5'b00010;
        iTGT_RD_DATA[1] = 64'hCAFE_F00D_1234_5678;
        @(negedge iCLK);
        iTGT_RD_VALID = '0;
        iTGT_RD_DATA = '0;
        checkOutput("post_cplreq", 64'(oCPL_REQ), 64'd1);
        checkOutput("post_status", 64'(oCPL_STATUS), 64'(CPL_SC));
        checkOutput("post_data", oCPL_DATA, 64'hCAFE_F00D_1234_5678);
        checkOutput("post_tag", 64'(oCPL_HDR1.tag), 64'h77);
        iCPL_ACK = 1'b1;
        @(negedge iCLK);
        iCPL_ACK = 1'b0;
        checkOutput("post_done", 64'(oDONE_PULSE), 64'd1);
        endTxn();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
